dm_responder: RTL and testbench
===============================

Name: dm_responder

Overview:
- Data-memory responder for the single-cycle CPU's DM port; the CPU drives DM_ena, DM_wena, DM_addr and write data, and this block returns read data in the same cycle.
- Word-addressed RAM is mapped at BASE_ADDR.
- A small MMIO window at MMIO_BASE exposes a cycle counter, a store counter, a sticky error status and an ID word.
- Instantiated beside the CPU in the top level and in CPU benches in place of a constant DM_data_out.

Parameters:
- ADDR_W, 11, log2 of RAM depth in 32-bit words (2048 words = 8 KiB).
- BASE_ADDR, 32'h10010000, byte address of RAM word 0.
- MMIO_BASE, 32'h10020000, byte address of MMIO register 0; must be 16-byte aligned.

Ports:
- clk  in  1  system clock; rising edge active.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- DM_ena  in  1  access enable from CPU.
- DM_wena  in  1  write enable from CPU; meaningful only when DM_ena=1.
- DM_addr  in  32  byte address from CPU.
- DM_data_in  in  32  write data from CPU.
- DM_data_out  out  32  read data to CPU; combinational.
- err_flag  out  1  OR of STATUS bits; registered.

Behaviour:
- Decode, evaluated every cycle:
  - RAM hit: offset = DM_addr - BASE_ADDR, unsigned compare, offset < 4*2^ADDR_W. Word index = offset[ADDR_W+1:2].
  - MMIO hit: DM_addr[31:4] == MMIO_BASE[31:4]. Register select = DM_addr[3:2].
  - Misaligned: DM_addr[1:0] != 0. Misalignment takes priority over any hit.
  - Miss: not misaligned, and neither RAM hit nor MMIO hit.
- Read (DM_ena=1, DM_wena=0):
  - DM_data_out is the addressed word in the same cycle, zero latency.
  - Misaligned or miss returns 0.
  - When DM_ena=0, DM_data_out=0.
- Write (DM_ena=1, DM_wena=1):
  - Commits on the rising clk edge.
  - A read of the same address in the next cycle returns the new data.
  - In the write cycle itself, DM_data_out shows the old data.
  - Misaligned or miss writes are dropped, with no state change other than STATUS.
- RAM: contents are not reset; they are undefined until written.
- MMIO registers:
  - 0x0 CYCLE, RO: +1 every clk edge while out of reset; wraps 32'hFFFFFFFF -> 0. A read returns the pre-edge value. Writes are ignored.
  - 0x4 STORES, RW: +1 on every committed RAM write; wraps. A CPU write loads DM_data_in. An MMIO write and a RAM write cannot coincide.
  - 0x8 STATUS:
    - Bit0 MISALIGN and bit1 RANGE are sticky; set on any enabled misaligned or miss access (read or write).
    - Write-1-to-clear using DM_data_in[1:0].
    - Bits 31:2 read 0.
    - A set and a clear of the same bit in one cycle cannot occur (a misaligned or miss access is never an MMIO write).
  - 0xC ID, RO: 32'hC0DE0031.
- err_flag: asserted the cycle after any STATUS bit becomes 1; deasserted the cycle after the last bit is cleared.
- Reset (rst=0, any time including mid-access):
  - CYCLE=0, STORES=0, STATUS=0, err_flag=0.
  - Any write in flight at the reset edge is discarded.
  - DM_data_out still follows the decode, so RAM reads remain valid during reset, but MMIO reads show reset values.
  - Counting resumes on the first clk edge after rst returns to 1.

Test Plan:
- Release reset, then write 32'hAFE10004 to 32'h10010004 and read it back the next cycle -> DM_data_out=32'hAFE10004. STORES reads 1.
- Write 32'hFFFF0000 to the last RAM word, 32'h10011FFC, then read 32'h10012000 -> the first access commits; the second returns 0, sets STATUS=2'b10, and err_flag rises one cycle later.
- Read 32'h10010002 -> DM_data_out=0 and STATUS[0]=1. Write 32'h1 to 32'h10020008 -> STATUS[0]=0; err_flag drops only if STATUS[1] is also 0.
- Write 32'hFFFFFFFF to STORES (32'h10020004), then perform one RAM store -> STORES reads 0.
- Read CYCLE on two consecutive cycles -> the values differ by 1. Read 32'h1002000C -> 32'hC0DE0031. Toggle DM_ena=0 -> DM_data_out=0.
- Assert rst for 3 cycles during a RAM write -> CYCLE, STORES and STATUS read 0 after release; a previously written word is still readable; the aborted write did not commit.

Source files
------------

// File: rtl/dm_responder.sv
`default_nettype none
// ============================================================================
// Module      : dm_responder
// Description : Data-memory responder for the single-cycle CPU's DM port.
//               Word-addressed RAM at BASE_ADDR with combinational reads, and
//               a 4-register MMIO window at MMIO_BASE:
//                 +0x0 CYCLE  (RO)  free-running edge counter
//                 +0x4 STORES (RW)  committed RAM store counter
//                 +0x8 STATUS (W1C) bit0 MISALIGN, bit1 RANGE (sticky)
//                 +0xC ID     (RO)  constant identification word
// Ports       : clk         system clock, rising edge active
//               rst         asynchronous reset, active low
//               DM_ena      access enable from CPU
//               DM_wena     write enable from CPU (qualified by DM_ena)
//               DM_addr     byte address from CPU
//               DM_data_in  write data from CPU
//               DM_data_out read data to CPU (combinational, zero latency)
//               err_flag    registered OR of the STATUS bits
// Revision    : 1.0 - initial release
// ============================================================================
module dm_responder #(
    parameter int          ADDR_W    = 11,
    parameter logic [31:0] BASE_ADDR = 32'h1001_0000,
    parameter logic [31:0] MMIO_BASE = 32'h1002_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        DM_ena,
    input  logic        DM_wena,
    input  logic [31:0] DM_addr,
    input  logic [31:0] DM_data_in,
    output logic [31:0] DM_data_out,
    output logic        err_flag
);

    localparam int          c_depth     = 1 << ADDR_W;
    // RAM size in bytes, one bit wider than the address so the bound is exact.
    localparam logic [32:0] c_ram_bytes = 33'd4 << ADDR_W;
    localparam logic [31:0] c_id_word   = 32'hC0DE_0031;

    localparam logic [1:0]  c_reg_cycle  = 2'd0;
    localparam logic [1:0]  c_reg_stores = 2'd1;
    localparam logic [1:0]  c_reg_status = 2'd2;
    localparam logic [1:0]  c_reg_id     = 2'd3;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [31:0]       w_offset;
    logic              w_misalign;
    logic              w_ram_hit;
    logic              w_mmio_hit;
    logic              w_ram_sel;
    logic              w_mmio_sel;
    logic              w_miss;
    logic [ADDR_W-1:0] w_word_idx;
    logic [1:0]        w_reg_sel;
    logic              w_ram_we;
    logic              w_mmio_we;

    // Subtraction wraps for addresses below BASE_ADDR, so a single unsigned
    // compare rejects both sides of the RAM window.
    assign w_offset   = DM_addr - BASE_ADDR;
    assign w_misalign = |DM_addr[1:0];
    assign w_ram_hit  = ({1'b0, w_offset} < c_ram_bytes);
    assign w_mmio_hit = (DM_addr[31:4] == MMIO_BASE[31:4]);

    // Misalignment overrides any hit; RAM wins if the windows ever overlap.
    assign w_ram_sel  = !w_misalign && w_ram_hit;
    assign w_mmio_sel = !w_misalign && !w_ram_hit && w_mmio_hit;
    assign w_miss     = !w_misalign && !w_ram_hit && !w_mmio_hit;

    assign w_word_idx = w_offset[ADDR_W+1:2];
    assign w_reg_sel  = DM_addr[3:2];

    assign w_ram_we   = DM_ena && DM_wena && w_ram_sel;
    assign w_mmio_we  = DM_ena && DM_wena && w_mmio_sel;

    // ------------------------------------------------------------------
    // RAM storage. Contents are never initialised; the reset term only
    // suppresses a store that is in flight while rst is low.
    // ------------------------------------------------------------------
    logic [31:0] mem_q [c_depth];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // no storage reset: pending write is simply dropped
        end else if (w_ram_we) begin
            mem_q[w_word_idx] <= DM_data_in;
        end
    end

    // ------------------------------------------------------------------
    // MMIO registers
    // ------------------------------------------------------------------
    logic [31:0] cycle_q,  cycle_d;
    logic [31:0] stores_q, stores_d;
    logic [1:0]  status_q, status_d;
    logic        err_flag_q, err_flag_d;
    logic [1:0]  w_status_set;
    logic [1:0]  w_status_clr;

    assign w_status_set = {DM_ena && w_miss, DM_ena && w_misalign};
    assign w_status_clr = (w_mmio_we && (w_reg_sel == c_reg_status))
                          ? DM_data_in[1:0] : 2'b00;

    always_comb begin
        cycle_d  = cycle_q + 32'd1;

        stores_d = stores_q;
        if (w_mmio_we && (w_reg_sel == c_reg_stores)) begin
            stores_d = DM_data_in;
        end else if (w_ram_we) begin
            stores_d = stores_q + 32'd1;
        end

        status_d   = (status_q & ~w_status_clr) | w_status_set;

        // Flag follows the STATUS register one cycle later.
        err_flag_d = |status_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_q    <= 32'd0;
            stores_q   <= 32'd0;
            status_q   <= 2'b00;
            err_flag_q <= 1'b0;
        end else begin
            cycle_q    <= cycle_d;
            stores_q   <= stores_d;
            status_q   <= status_d;
            err_flag_q <= err_flag_d;
        end
    end

    assign err_flag = err_flag_q;

    // ------------------------------------------------------------------
    // Read mux. Shows pre-edge state, so a write cycle returns old data.
    // ------------------------------------------------------------------
    always_comb begin
        DM_data_out = 32'd0;
        if (DM_ena) begin
            if (w_ram_sel) begin
                DM_data_out = mem_q[w_word_idx];
            end else if (w_mmio_sel) begin
                case (w_reg_sel)
                    c_reg_cycle:  DM_data_out = cycle_q;
                    c_reg_stores: DM_data_out = stores_q;
                    c_reg_status: DM_data_out = {30'd0, status_q};
                    c_reg_id:     DM_data_out = c_id_word;
                    default:      DM_data_out = 32'd0;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dm_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dm_responder
// Description : Self-checking bench for dm_responder. Directed stimulus
//               pushes expected values into a scoreboard queue; a monitor
//               pops and compares them mid-cycle on the falling clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dm_responder;

    localparam logic [31:0] RAM  = 32'h1001_0000;
    localparam logic [31:0] MMIO = 32'h1002_0000;

    logic        clk;
    logic        rst;
    logic        DM_ena;
    logic        DM_wena;
    logic [31:0] DM_addr;
    logic [31:0] DM_data_in;
    logic [31:0] DM_data_out;
    logic        err_flag;

    dm_responder #(
        .ADDR_W    (11),
        .BASE_ADDR (RAM),
        .MMIO_BASE (MMIO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .DM_ena      (DM_ena),
        .DM_wena     (DM_wena),
        .DM_addr     (DM_addr),
        .DM_data_in  (DM_data_in),
        .DM_data_out (DM_data_out),
        .err_flag    (err_flag)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        bit          is_err;
        string       name;
        logic [31:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   pend;
    int   n_cmp;
    int   n_fail;
    int   tstep;   // steps since the latest reset release = expected CYCLE

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic step(input logic ena, input logic wena,
                        input logic [31:0] addr, input logic [31:0] data);
        @(posedge clk);
        #1;
        DM_ena     = ena;
        DM_wena    = wena;
        DM_addr    = addr;
        DM_data_in = data;
        tstep++;
    endtask

    task automatic exp_data(input string nm, input logic [31:0] v);
        exp_t e;
        e.is_err = 1'b0;
        e.name   = nm;
        e.exp    = v;
        sb_q.push_back(e);
        pend++;
    endtask

    task automatic exp_err(input string nm, input logic v);
        exp_t e;
        e.is_err = 1'b1;
        e.name   = nm;
        e.exp    = {31'd0, v};
        sb_q.push_back(e);
        pend++;
    endtask

    // ------------------------------------------------------------------
    // Monitor: compare everything expected for this cycle
    // ------------------------------------------------------------------
    initial begin
        exp_t        e;
        logic [31:0] act;
        forever begin
            @(negedge clk);
            for (int k = 0; k < pend; k++) begin
                n_cmp++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL scoreboard_underflow: no expected entry");
                end else begin
                    e   = sb_q.pop_front();
                    act = e.is_err ? {31'd0, err_flag} : DM_data_out;
                    if (act !== e.exp) begin
                        n_fail++;
                        $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
                    end
                end
            end
            pend = 0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        pend       = 0;
        n_cmp      = 0;
        n_fail     = 0;
        tstep      = 0;
        rst        = 1'b0;
        DM_ena     = 1'b0;
        DM_wena    = 1'b0;
        DM_addr    = 32'd0;
        DM_data_in = 32'd0;

        step(1'b0, 1'b0, 32'd0, 32'd0);
        step(1'b1, 1'b0, MMIO + 32'h0, 32'd0);
        exp_data("rst_cycle", 32'd0);
        exp_err ("rst_err", 1'b0);

        // release reset
        @(posedge clk);
        #1;
        rst    = 1'b1;
        DM_ena = 1'b0;
        tstep  = 0;

        step(1'b1, 1'b1, RAM + 32'h4, 32'hAFE1_0004);                 // T1
        step(1'b1, 1'b0, RAM + 32'h4, 32'd0);                         // T2
        exp_data("ram_readback", 32'hAFE1_0004);
        step(1'b1, 1'b0, MMIO + 32'h4, 32'd0);                        // T3
        exp_data("stores_one", 32'd1);

        step(1'b1, 1'b1, 32'h1001_1FFC, 32'hFFFF_0000);               // T4
        step(1'b1, 1'b0, 32'h1001_2000, 32'd0);                       // T5
        exp_data("range_miss_read", 32'd0);
        step(1'b1, 1'b0, MMIO + 32'h8, 32'd0);                        // T6
        exp_data("status_range", 32'd2);
        exp_err ("err_before_rise", 1'b0);
        step(1'b1, 1'b0, 32'h1001_1FFC, 32'd0);                       // T7
        exp_data("last_word", 32'hFFFF_0000);
        exp_err ("err_rise", 1'b1);

        step(1'b1, 1'b0, 32'h1001_0002, 32'd0);                       // T8
        exp_data("misalign_read", 32'd0);
        step(1'b1, 1'b0, MMIO + 32'h8, 32'd0);                        // T9
        exp_data("status_both", 32'd3);
        step(1'b1, 1'b1, MMIO + 32'h8, 32'd1);                        // T10
        exp_data("status_write_cycle", 32'd3);
        step(1'b1, 1'b0, MMIO + 32'h8, 32'd0);                        // T11
        exp_data("status_clear_bit0", 32'd2);
        exp_err ("err_hold", 1'b1);
        step(1'b1, 1'b1, MMIO + 32'h8, 32'd2);                        // T12
        step(1'b1, 1'b0, MMIO + 32'h8, 32'd0);                        // T13
        exp_data("status_clear_all", 32'd0);
        exp_err ("err_lag", 1'b1);
        step(1'b0, 1'b0, MMIO + 32'hC, 32'd0);                        // T14
        exp_data("ena_low_zero", 32'd0);
        exp_err ("err_fall", 1'b0);

        step(1'b1, 1'b1, MMIO + 32'h4, 32'hFFFF_FFFF);                // T15
        step(1'b1, 1'b0, MMIO + 32'h4, 32'd0);                        // T16
        exp_data("stores_load", 32'hFFFF_FFFF);
        step(1'b1, 1'b1, RAM + 32'h8, 32'h1234_5678);                 // T17
        step(1'b1, 1'b0, MMIO + 32'h4, 32'd0);                        // T18
        exp_data("stores_wrap", 32'd0);

        step(1'b1, 1'b0, MMIO + 32'h0, 32'd0);                        // T19
        exp_data("cycle_a", 32'(tstep));
        step(1'b1, 1'b0, MMIO + 32'h0, 32'd0);                        // T20
        exp_data("cycle_b", 32'(tstep));
        step(1'b1, 1'b0, MMIO + 32'hC, 32'd0);                        // T21
        exp_data("id_word", 32'hC0DE_0031);
        step(1'b1, 1'b1, MMIO + 32'h0, 32'd0);                        // T22
        step(1'b1, 1'b0, MMIO + 32'h0, 32'd0);                        // T23
        exp_data("cycle_ro", 32'(tstep));

        step(1'b1, 1'b1, 32'h1003_0000, 32'd5);                       // T24
        step(1'b1, 1'b0, MMIO + 32'h8, 32'd0);                        // T25
        exp_data("miss_write_status", 32'd2);
        step(1'b1, 1'b1, RAM + 32'hC, 32'h0000_0BAD);                 // T26
        step(1'b1, 1'b0, MMIO + 32'h4, 32'd0);                        // T27
        exp_data("stores_pre_reset", 32'd1);
        exp_err ("err_pre_reset", 1'b1);

        // reset asserted for three edges while a RAM write is presented
        @(posedge clk);
        #1;
        rst        = 1'b0;
        DM_ena     = 1'b1;
        DM_wena    = 1'b1;
        DM_addr    = RAM + 32'h4;
        DM_data_in = 32'hDEAD_BEEF;
        exp_data("rst_ram_read", 32'hAFE1_0004);
        exp_err ("rst_err_clear", 1'b0);
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst     = 1'b1;
        DM_ena  = 1'b0;
        DM_wena = 1'b0;
        tstep   = 0;

        step(1'b1, 1'b0, MMIO + 32'h0, 32'd0);                        // R1
        exp_data("post_rst_cycle", 32'(tstep));
        step(1'b1, 1'b0, MMIO + 32'h4, 32'd0);                        // R2
        exp_data("post_rst_stores", 32'd0);
        step(1'b1, 1'b0, MMIO + 32'h8, 32'd0);                        // R3
        exp_data("post_rst_status", 32'd0);
        exp_err ("post_rst_err", 1'b0);
        step(1'b1, 1'b0, RAM + 32'h4, 32'd0);                         // R4
        exp_data("aborted_write", 32'hAFE1_0004);
        step(1'b1, 1'b0, RAM + 32'h8, 32'd0);                         // R5
        exp_data("retained_word", 32'h1234_5678);

        @(posedge clk);
        #1;
        DM_ena = 1'b0;
        @(negedge clk);
        #1;
        if (sb_q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
